// File: rtl/serial_word_rx_if.sv
// Bundle between the serial bit source, the receiver and the word consumer.
interface serial_word_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             sin;
  logic             sin_en;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_perr;
  logic             frame_err;
  logic             overrun;

  modport master (
    output sin, sin_en, out_ready,
    input  out_data, out_valid, out_perr, frame_err, overrun
  );

  modport slave (
    input  sin, sin_en, out_ready,
    output out_data, out_valid, out_perr, frame_err, overrun
  );
endinterface

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: start bit, WIDTH data bits MSB-first, optional
// even parity and a stop bit, delivered through a one-entry valid/ready buffer.
module serial_word_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  serial_word_rx_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic             par;
  logic             perr_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             out_perr_q;
  logic             frame_err_q;
  logic             overrun_q;

  // The buffer can take a new word if empty or being drained this edge.
  logic             buf_free_c;
  assign buf_free_c = !valid_q || bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shift       <= '0;
      par         <= 1'b0;
      perr_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      out_perr_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (bus.sin_en) begin
        case (state)
          IDLE: begin
            if (!bus.sin) begin
              state  <= DATA;
              cnt    <= '0;
              par    <= 1'b0;
              perr_q <= 1'b0;
            end
          end
          DATA: begin
            shift <= {shift[WIDTH-2:0], bus.sin};
            par   <= par ^ bus.sin;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state <= PARITY_EN ? PARITY : STOP;
            end
          end
          PARITY: begin
            perr_q <= par ^ bus.sin;
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (bus.sin) begin
              if (buf_free_c) begin
                data_q     <= shift;
                out_perr_q <= PARITY_EN ? perr_q : 1'b0;
                valid_q    <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_perr  = out_perr_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx (WIDTH=8, PARITY_EN=1).
module tb_serial_word_rx;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_word_rx_if #(.WIDTH(8)) bus ();

  serial_word_rx #(.WIDTH(8), .PARITY_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input; returns 1ns after the consuming edge.
  task automatic tick(input logic b, input logic en);
    bus.sin    = b;
    bus.sin_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic pbit, input logic stop);
    tick(1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) tick(w[i], 1'b1);
    tick(pbit, 1'b1);
    tick(stop, 1'b1);
  endtask

  // One strobed bit preceded by two unstrobed cycles carrying noise.
  task automatic sparse_bit(input logic b);
    tick(1'($urandom), 1'b0);
    tick(1'($urandom), 1'b0);
    tick(b, 1'b1);
  endtask

  initial begin
    logic [7:0] w;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.sin       = 1'b1;
    bus.sin_en    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'h00);
    chk("rst_perr", 32'(bus.out_perr), 32'd0);
    chk("rst_ferr", 32'(bus.frame_err), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);

    // Basic receive of A5, watching for exact latency and one-cycle valid
    tick(1'b0, 1'b1);
    w = 8'hA5;
    for (int i = 7; i >= 0; i--) tick(w[i], 1'b1);
    tick(1'b0, 1'b1);
    chk("basic_valid_before_stop", 32'(bus.out_valid), 32'd0);
    tick(1'b1, 1'b1);
    chk("basic_valid", 32'(bus.out_valid), 32'd1);
    chk("basic_data", 32'(bus.out_data), 32'hA5);
    chk("basic_perr", 32'(bus.out_perr), 32'd0);
    tick(1'b1, 1'b0);
    chk("basic_valid_one_cycle", 32'(bus.out_valid), 32'd0);

    // Parity error
    send_frame(8'hA5, 1'b1, 1'b1);
    chk("perr_valid", 32'(bus.out_valid), 32'd1);
    chk("perr_data", 32'(bus.out_data), 32'hA5);
    chk("perr_flag", 32'(bus.out_perr), 32'd1);
    chk("perr_ferr", 32'(bus.frame_err), 32'd0);
    tick(1'b1, 1'b0);

    // Framing error, then a good 81 frame
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("ferr_pulse", 32'(bus.frame_err), 32'd1);
    chk("ferr_valid", 32'(bus.out_valid), 32'd0);
    tick(1'b1, 1'b0);
    chk("ferr_pulse_end", 32'(bus.frame_err), 32'd0);
    send_frame(8'h81, 1'b0, 1'b1);
    chk("after_ferr_valid", 32'(bus.out_valid), 32'd1);
    chk("after_ferr_data", 32'(bus.out_data), 32'h81);
    chk("after_ferr_perr", 32'(bus.out_perr), 32'd0);
    tick(1'b1, 1'b0);

    // Backpressure and overrun
    bus.out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_data", 32'(bus.out_data), 32'h11);
    tick(1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    chk("ovr_pulse", 32'(bus.overrun), 32'd1);
    chk("ovr_hold_data", 32'(bus.out_data), 32'h11);
    chk("ovr_hold_valid", 32'(bus.out_valid), 32'd1);
    tick(1'b1, 1'b0);
    chk("ovr_pulse_end", 32'(bus.overrun), 32'd0);
    chk("ovr_hold_data2", 32'(bus.out_data), 32'h11);
    bus.out_ready = 1'b1;
    tick(1'b1, 1'b0);
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // Sparse strobes with noise between strobes
    w = 8'hC3;
    sparse_bit(1'b0);
    for (int i = 7; i >= 0; i--) sparse_bit(w[i]);
    sparse_bit(1'b0);
    bus.out_ready = 1'b0;
    sparse_bit(1'b1);
    chk("sparse_valid", 32'(bus.out_valid), 32'd1);
    chk("sparse_data", 32'(bus.out_data), 32'hC3);
    chk("sparse_perr", 32'(bus.out_perr), 32'd0);

    // Asynchronous reset four bits into an FF frame, buffer still full
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    bus.sin_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("amid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("amid_rst_data", 32'(bus.out_data), 32'h00);
    chk("amid_rst_perr", 32'(bus.out_perr), 32'd0);
    chk("amid_rst_ferr", 32'(bus.frame_err), 32'd0);
    chk("amid_rst_ovr", 32'(bus.overrun), 32'd0);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick(1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_data", 32'(bus.out_data), 32'h5A);
    chk("post_rst_perr", 32'(bus.out_perr), 32'd0);
    tick(1'b1, 1'b0);
    chk("post_rst_drain", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Serial-to-parallel receiver that sits directly downstream of the one-bit shift-register chain and consumes the chain's serial output bit.
- Detects a start bit, then assembles WIDTH data bits MSB-first, with an optional even-parity bit and a stop bit.
- Presents each completed word through a one-entry output buffer with a valid/ready handshake.
- Flags parity, framing and overrun errors.

Parameters:
- WIDTH, 8, number of data bits per frame (at least 2).
- PARITY_EN, 1, when 1 an even-parity bit follows the data bits; when 0 there is no parity bit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial bit from the upstream shift-register chain output; line idles at 1.
- sin_en  input  1  bit strobe; sin is sampled only on cycles where sin_en=1.
- out_ready  input  1  consumer accepts the buffered word when out_valid=1 and out_ready=1.
- out_data  output  WIDTH  received word, first-received bit in the MSB.
- out_valid  output  1  out_data, out_perr are valid.
- out_perr  output  1  parity error for the word in the buffer (stored with it).
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE; shift register, bit counter and parity accumulator cleared.
  - out_data=0, out_valid=0, out_perr=0, frame_err=0, overrun=0.
- All state changes occur on rising clk edges only. Cycles with sin_en=0 hold FSM, counter, shift register and parity unchanged.
- State IDLE:
  - sin_en=1 and sin=0 (start bit): go to DATA; clear counter and parity.
  - sin=1: stay in IDLE.
- State DATA:
  - Each strobe: shift = {shift[WIDTH-2:0], sin}; parity ^= sin; counter++.
  - On the WIDTH-th data bit, go to PARITY if PARITY_EN=1, else go to STOP.
- State PARITY: on strobe, perr_next = parity ^ sin (nonzero means odd total); go to STOP.
- State STOP: on strobe, always return to IDLE.
  - sin=1 (valid stop): the word completes.
  - sin=0: word discarded; frame_err=1 for the next cycle only; buffer unaffected.
- A new start bit is not recognised on the same strobe that samples the stop bit. The earliest start bit is the next strobe.
- Word delivery, on completion of a valid frame:
  - If the buffer is empty, or out_valid=1 and out_ready=1 in the same cycle: load out_data, out_perr; out_valid=1 from the next cycle.
  - Latency: out_valid rises on the cycle after the stop-bit strobe edge.
  - Otherwise the word is dropped; overrun=1 for one cycle; buffer contents unchanged.
- Handshake:
  - out_valid=1 and out_ready=1 at an edge: buffer consumed.
  - out_valid falls next cycle unless a simultaneous completion reloads it.
  - out_data and out_perr are stable while out_valid=1 and out_ready=0.
- With PARITY_EN=0, out_perr is always 0.
- out_ready is ignored while out_valid=0.
- Counter width is $clog2(WIDTH+1); no wrap within a frame.

Test Plan:
- Basic receive: WIDTH=8, PARITY_EN=1, out_ready=1, sin_en=1 every cycle; stream 0, 1,0,1,0,0,1,0,1, 0, 1 → out_data=8'hA5, out_perr=0, out_valid high exactly 1 cycle, one cycle after the stop bit.
- Parity error: same stream with parity bit 1 → out_data=8'hA5, out_perr=1, frame_err=0.
- Framing error: stream 0, 8'h3C MSB-first, parity 0, stop 0 → frame_err pulses 1 cycle, out_valid stays 0; a following valid 8'h81 frame is then received correctly.
- Backpressure and overrun:
  - out_ready=0; send 8'h11 then 8'h22 → out_data holds 8'h11 throughout, overrun pulses once at the 8'h22 stop.
  - Raise out_ready → 8'h11 consumed, out_valid falls.
- Sparse strobes: sin_en asserted every 3rd cycle, sin toggling randomly on unstrobed cycles; frame for 8'hC3 → out_data=8'hC3, out_perr=0.
- Reset mid-frame: assert rst asynchronously after 4 data bits of 8'hFF → all outputs 0 immediately, FSM in IDLE. After release, a full 8'h5A frame yields out_data=8'h5A with no stale bits.
